fifo_rr_scheduler: RTL

- Drains four upstream FIFO channels (virtual-channel/TLP-class queues) into one downstream FIFO.
- Issues at most one pop per cycle to the upstream FIFOs, selected by round-robin.
- Applies burst limiting and almost_full urgency promotion.
- Registers the popped word and pushes it downstream, respecting downstream full/almost_full flags.
- Sits between the per-class FIFOs and the shared egress FIFO of the TLP datapath.

---
 rtl/fifo_rr_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of four upstream FIFOs into one downstream FIFO, with burst limit and almost_full urgency.
// Latency: pop -> push_out one cycle. Backpressure: no pop while downstream full/almost_full; an in-flight word still pushes.
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int BURST      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              empty,
  input  logic [3:0]              almost_empty,
  input  logic [3:0]              almost_full,
  input  logic [4*DATA_WIDTH-1:0] q_in,
  input  logic                    out_full,
  input  logic                    out_almost_full,
  output logic [3:0]              pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    push_out,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    error
);

  typedef enum logic {IDLE, SERVE} state_t;

  localparam logic [3:0] BURST_L = 4'(BURST);

  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] pop_prev_q, pop_prev_d;
  logic       push_q, push_d;
  logic [1:0] pidx_q, pidx_d;
  logic       error_q, error_d;

  logic       stall;
  logic [3:0] elig;
  logic [3:0] urgent;
  logic [3:0] cand;
  logic [1:0] sel;
  logic       can_cont;

  // Upstream flags lag by a cycle: a channel popped last cycle that already
  // reported almost_empty may really be empty now.
  assign elig     = ~empty & ~(pop_prev_q & almost_empty);
  assign stall    = out_almost_full | out_full;
  assign urgent   = elig & almost_full;
  assign cand     = (|urgent) ? urgent : elig;
  assign can_cont = elig[grant_q] & ~stall & (burst_cnt_q < BURST_L);

  always_comb begin
    logic [1:0] idx;
    logic       found;
    sel   = rr_ptr_q;
    found = 1'b0;
    idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + k[1:0];
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      pop_prev_q  <= '0;
      push_q      <= 1'b0;
      pidx_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      pop_prev_q  <= pop_prev_d;
      push_q      <= push_d;
      pidx_q      <= pidx_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (!stall && (|elig)) begin
          state_d     = SERVE;
          grant_d     = sel;
          burst_cnt_d = 4'd1;
        end
      end
      SERVE: begin
        if (can_cont) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          // Rotation always passes through IDLE, giving the mandatory gap cycle.
          rr_ptr_d    = grant_q + 2'd1;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pop_prev_d = pop;
    push_d     = |pop;
    pidx_d     = pidx_q;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) pidx_d = i[1:0];
    end
    error_d = error_q | (push_q & out_full);
  end

  always_comb begin
    pop  = '0;
    busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stall && (|elig)) pop[sel] = 1'b1;
      end
      SERVE: begin
        busy = 1'b1;
        if (can_cont) pop[grant_q] = 1'b1;
      end
      default: pop = '0;
    endcase
    if (!reset) pop = '0;
  end

  // Upstream read data arrives the cycle after the pop, alongside push_out.
  assign data_out = push_q ? q_in[int'(pidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign push_out = push_q;
  assign grant_id = grant_q;
  assign error    = error_q;

endmodule
